// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_encoder
// Description : USB transmit line encoder. Consumes the serial bit stream of
//               an upstream parallel-to-serial shift register, applies bit
//               stuffing (a 0 after six consecutive 1s) and NRZI encoding,
//               drives D+/D-, and appends end-of-packet signalling
//               (SE0 for EOP_SE0_BITS bit periods, then one J bit).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   tx_start     in   one-cycle packet start request, honoured only when idle
//   serial_in    in   current data bit from the shift register
//   last_bit     in   high while serial_in carries the final data bit
//   shift_enable out  one-cycle pulse advancing the shift register
//   dplus_out    out  D+ line drive
//   dminus_out   out  D- line drive
//   tx_busy      out  high from start acceptance until IDLE is re-entered
//   tx_done      out  one-cycle pulse on return to IDLE
//   tx_oe        out  (only with USB_TX_OE_EN) registered output enable
// Optional feature macro: USB_TX_OE_EN adds the tx_oe output.
// ============================================================================
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8,  // 2..255
    parameter int EOP_SE0_BITS = 2   // 1..3
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_start,
    input  logic serial_in,
    input  logic last_bit,
    output logic shift_enable,
    output logic dplus_out,
    output logic dminus_out,
    output logic tx_busy,
`ifdef USB_TX_OE_EN
    output logic tx_oe,
`endif
    output logic tx_done
);

    localparam logic [7:0] c_tick_max = 8'(CLKS_PER_BIT - 1);
    localparam logic [1:0] c_eop_last = 2'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DATA    = 3'd1,
        S_STUFF   = 3'd2,
        S_EOP_SE0 = 3'd3,
        S_EOP_J   = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] ones_q, ones_d;
    logic [1:0] eop_q, eop_d;
    logic       last_q, last_d;
    logic       dp_q, dp_d;
    logic       dm_q, dm_d;
    logic       shift_q, shift_d;
    logic       done_q, done_d;
    logic       w_tick;
    logic       w_data_dec;

    assign w_tick = (timer_q == c_tick_max);

    always_comb begin
        state_d    = state_q;
        timer_d    = (state_q == S_IDLE || w_tick) ? 8'd0 : timer_q + 8'd1;
        ones_d     = ones_q;
        eop_d      = eop_q;
        last_d     = last_q;
        dp_d       = dp_q;
        dm_d       = dm_q;
        shift_d    = 1'b0;
        done_d     = 1'b0;
        w_data_dec = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    w_data_dec = 1'b1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    // Stuffing outranks the end check so a final run of six
                    // 1s still gets its stuff bit before EOP.
                    if (ones_q == 3'd6) begin
                        state_d = S_STUFF;
                        ones_d  = 3'd0;
                        dp_d    = ~dp_q;
                        dm_d    = ~dm_q;
                    end else if (last_q) begin
                        state_d = S_EOP_SE0;
                        eop_d   = 2'd0;
                        dp_d    = 1'b0;
                        dm_d    = 1'b0;
                    end else begin
                        w_data_dec = 1'b1;
                    end
                end
            end
            S_STUFF: begin
                if (w_tick) begin
                    // last_q still holds the flag of the bit that preceded
                    // the stuff bit.
                    if (last_q) begin
                        state_d = S_EOP_SE0;
                        eop_d   = 2'd0;
                        dp_d    = 1'b0;
                        dm_d    = 1'b0;
                    end else begin
                        w_data_dec = 1'b1;
                    end
                end
            end
            S_EOP_SE0: begin
                if (w_tick) begin
                    if (eop_q == c_eop_last) begin
                        state_d = S_EOP_J;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                    end else begin
                        eop_d = eop_q + 2'd1;
                    end
                end
            end
            S_EOP_J: begin
                if (w_tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    ones_d  = 3'd0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
            end
        endcase

        // Shared data-bit decision: NRZI toggles on 0 and holds on 1.
        if (w_data_dec) begin
            state_d = S_DATA;
            last_d  = last_bit;
            shift_d = 1'b1;
            if (serial_in) begin
                ones_d = ones_q + 3'd1;
            end else begin
                ones_d = 3'd0;
                dp_d   = ~dp_q;
                dm_d   = ~dm_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= 8'd0;
            ones_q  <= 3'd0;
            eop_q   <= 2'd0;
            last_q  <= 1'b0;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ones_q  <= ones_d;
            eop_q   <= eop_d;
            last_q  <= last_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

`ifdef USB_TX_OE_EN
    logic tx_oe_q;

    // Rises with the first data bit, falls on the edge entering IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_oe_q <= 1'b0;
        end else if (state_q == S_IDLE && tx_start) begin
            tx_oe_q <= 1'b1;
        end else if (state_d == S_IDLE) begin
            tx_oe_q <= 1'b0;
        end
    end

    assign tx_oe = tx_oe_q;
`endif

    assign shift_enable = shift_q;
    assign dplus_out    = dp_q;
    assign dminus_out   = dm_q;
    assign tx_busy      = (state_q != S_IDLE);
    assign tx_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_encoder
// Description : Directed self-checking bench for usb_tx_encoder. Each packet
//               is given as a data-bit string plus a hand-computed string of
//               expected line symbols per bit period (J, K, S=SE0) and a mask
//               of which bit periods carry a shift_enable pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_encoder;

    logic clk = 1'b0;
    logic rst;
    logic tx_start;
    logic serial_in;
    logic last_bit;
    logic shift_enable;
    logic dplus_out;
    logic dminus_out;
    logic tx_busy;
    logic tx_done;
`ifdef USB_TX_OE_EN
    logic tx_oe;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    usb_tx_encoder #(
        .CLKS_PER_BIT(8),
        .EOP_SE0_BITS(2)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .serial_in   (serial_in),
        .last_bit    (last_bit),
        .shift_enable(shift_enable),
        .dplus_out   (dplus_out),
        .dminus_out  (dminus_out),
        .tx_busy     (tx_busy),
`ifdef USB_TX_OE_EN
        .tx_oe       (tx_oe),
`endif
        .tx_done     (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] sym_code(input byte ch);
        case (ch)
            "J":     return 2'b10;
            "K":     return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Plays one packet. extra_c: cycle index of a redundant tx_start pulse
    // (-1 none). abort_c: cycle index at which rst is asserted (-1 none).
    task automatic run_packet(input string name, input string bits, input string syms,
                              input string mask, input int extra_c, input int abort_c);
        int idx;
        int shifts;
        int n;
        int total;
        idx    = 0;
        shifts = 0;
        n      = bits.len();
        total  = syms.len() * 8;

        @(negedge clk);
        serial_in = (bits[0] == "1");
        last_bit  = (n == 1);
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;

        for (int c = 0; c < total; c++) begin
            if (c == abort_c) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({name, " abort line"}, {dplus_out, dminus_out}, 2'b10);
                check({name, " abort busy"}, tx_busy, 1'b0);
                check({name, " abort shift"}, shift_enable, 1'b0);
                check({name, " abort done"}, tx_done, 1'b0);
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    check({name, " abort no done"}, tx_done, 1'b0);
                    check({name, " abort idle line"}, {dplus_out, dminus_out}, 2'b10);
                end
                return;
            end
            check({name, " line"}, {dplus_out, dminus_out}, sym_code(syms[c / 8]));
            check({name, " shift"}, shift_enable, (c % 8 == 0) && (mask[c / 8] == "1"));
            check({name, " busy"}, tx_busy, 1'b1);
            check({name, " done"}, tx_done, 1'b0);
`ifdef USB_TX_OE_EN
            check({name, " oe"}, tx_oe, 1'b1);
`endif
            if (shift_enable) begin
                shifts++;
                idx++;
                serial_in = (idx < n) ? (bits[idx] == "1") : 1'b0;
                last_bit  = (idx == n - 1);
            end
            tx_start = (c == extra_c);
            @(negedge clk);
        end

        check({name, " done pulse"}, tx_done, 1'b1);
        check({name, " busy end"}, tx_busy, 1'b0);
        check({name, " line end"}, {dplus_out, dminus_out}, 2'b10);
        check({name, " shift count"}, shifts, n);
`ifdef USB_TX_OE_EN
        check({name, " oe end"}, tx_oe, 1'b0);
`endif
        @(negedge clk);
        check({name, " done width"}, tx_done, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        tx_start  = 1'b0;
        serial_in = 1'b0;
        last_bit  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            check("idle line", {dplus_out, dminus_out}, 2'b10);
            check("idle shift", shift_enable, 1'b0);
            check("idle busy", tx_busy, 1'b0);
            check("idle done", tx_done, 1'b0);
            @(negedge clk);
        end

        run_packet("sync",     "00000001", "KJKJKJKKSSJ",  "11111111000",  -1, -1);
        run_packet("stuff8",   "11111111", "JJJJJJKKKSSJ", "111111011000", -1, -1);
        run_packet("stuffend", "111111",   "JJJJJJKSSJ",   "1111110000",   -1, -1);
        run_packet("midstuff", "01111110", "KKKKKKKJKSSJ", "111111101000", -1, -1);
        run_packet("busyign",  "10110",    "JKKKJSSJ",     "11111000",     20, -1);
        run_packet("abort",    "11111111", "JJJJJJKKKSSJ", "111111011000", -1, 20);
        run_packet("postabort","11111111", "JJJJJJKKKSSJ", "111111011000", -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
